// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the execute-stage result, performs a
// word load/store into a local data memory with a fixed multi-cycle latency,
// and presents registered MEM/WB outputs to write-back.
module mem_stage #(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned ACCESS_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_flag_mem_in,
  output logic        stall_flag_mem_out,
  input  logic        valid_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic [4:0]  rd_in,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  output logic        mem_busy,
  output logic        valid_out,
  output logic [31:0] read_data,
  output logic [31:0] alu_result_out,
  output logic [4:0]  rd_out,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic        misaligned
);

  localparam int unsigned CntW = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(ACCESS_LAT - 1);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [31:0]       mem_q [DEPTH];

  // Fields latched at acceptance of a memory operation
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [4:0]        rd_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic              reg_write_q;
  logic              mem_to_reg_q;

  // Registered outputs
  logic              stall_out_q;
  logic              busy_q;
  logic              valid_out_q;
  logic [31:0]       read_data_q;
  logic [31:0]       alu_out_q;
  logic [4:0]        rd_out_q;
  logic              reg_write_out_q;
  logic              mem_to_reg_out_q;
  logic              misaligned_q;

  logic [ADDR_W-1:0] idx;
  logic              acc_misaligned;
  logic [31:0]       read_data_d;

  assign idx            = addr_q[ADDR_W+1:2];
  assign acc_misaligned = (addr_q[1:0] != 2'b00);

  // Data returned on completion: write-first when both read and write are set
  always_comb begin
    read_data_d = '0;
    if (!acc_misaligned) begin
      if (mem_read_q && mem_write_q) begin
        read_data_d = wdata_q;
      end else if (mem_read_q) begin
        read_data_d = mem_q[idx];
      end
    end
  end

  // Stage FSM, memory array and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StIdle;
      cnt_q            <= '0;
      addr_q           <= '0;
      wdata_q          <= '0;
      rd_q             <= '0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      reg_write_q      <= 1'b0;
      mem_to_reg_q     <= 1'b0;
      stall_out_q      <= 1'b0;
      busy_q           <= 1'b0;
      valid_out_q      <= 1'b0;
      read_data_q      <= '0;
      alu_out_q        <= '0;
      rd_out_q         <= '0;
      reg_write_out_q  <= 1'b0;
      mem_to_reg_out_q <= 1'b0;
      misaligned_q     <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      stall_out_q <= stall_flag_mem_in;
      if (stall_flag_mem_in) begin
        // Freeze everything except the valid pulse
        valid_out_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            valid_out_q <= 1'b0;
            if (valid_in) begin
              if (MemRead || MemWrite) begin
                addr_q       <= alu_result;
                wdata_q      <= write_data;
                rd_q         <= rd_in;
                mem_read_q   <= MemRead;
                mem_write_q  <= MemWrite;
                reg_write_q  <= RegWrite;
                mem_to_reg_q <= MemtoReg;
                cnt_q        <= CntInit;
                busy_q       <= 1'b1;
                state_q      <= StAccess;
              end else begin
                alu_out_q        <= alu_result;
                rd_out_q         <= rd_in;
                reg_write_out_q  <= RegWrite;
                mem_to_reg_out_q <= MemtoReg;
                read_data_q      <= '0;
                valid_out_q      <= 1'b1;
              end
            end
          end
          StAccess: begin
            if (cnt_q == '0) begin
              if (mem_write_q && !acc_misaligned) begin
                mem_q[idx] <= wdata_q;
              end
              if (acc_misaligned) begin
                misaligned_q <= 1'b1;
              end
              read_data_q      <= read_data_d;
              alu_out_q        <= addr_q;
              rd_out_q         <= rd_q;
              reg_write_out_q  <= reg_write_q;
              mem_to_reg_out_q <= mem_to_reg_q;
              valid_out_q      <= 1'b1;
              busy_q           <= 1'b0;
              state_q          <= StIdle;
            end else begin
              cnt_q       <= cnt_q - 1'b1;
              valid_out_q <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign stall_flag_mem_out = stall_out_q;
  assign mem_busy           = busy_q;
  assign valid_out          = valid_out_q;
  assign read_data          = read_data_q;
  assign alu_result_out     = alu_out_q;
  assign rd_out             = rd_out_q;
  assign RegWrite_out       = reg_write_out_q;
  assign MemtoReg_out       = mem_to_reg_out_q;
  assign misaligned         = misaligned_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the execute stage.
- Latches the execute result, the store data, the destination register and the control bits.
- Performs a word load or store into a local data memory with a fixed multi-cycle access latency.
- Presents registered MEM/WB outputs to write-back and raises mem_busy so upstream stages hold while an access is in flight.

Parameters:
DEPTH, 256, number of 32-bit words in data memory (power of two)
ADDR_W, 8, log2(DEPTH); word-index width
ACCESS_LAT, 2, cycles a load/store occupies the stage (>=1)

Ports:
clk  input  1  clock; all state changes on posedge
reset  input  1  synchronous, active-high reset
stall_flag_mem_in  input  1  upstream stall; 1 = freeze stage
stall_flag_mem_out  output  1  registered copy of stall_flag_mem_in
valid_in  input  1  execute stage presents an instruction this cycle
alu_result  input  32  byte address (load/store) or ALU result (other)
write_data  input  32  store data (rt value)
rd_in  input  5  destination register
MemRead  input  1  load
MemWrite  input  1  store
RegWrite  input  1  write-back enable, passed through
MemtoReg  input  1  write-back select, passed through
mem_busy  output  1  access in flight; upstream must hold its inputs
valid_out  output  1  MEM/WB outputs valid this cycle
read_data  output  32  loaded word
alu_result_out  output  32  alu_result passed through
rd_out  output  5  rd_in passed through
RegWrite_out  output  1  passed through
MemtoReg_out  output  1  passed through
misaligned  output  1  sticky: a load/store had alu_result[1:0] != 0

Behaviour:
- Reset (synchronous, active-high): all outputs are 0, FSM goes to IDLE, the access counter is 0 and every memory word is cleared to 0. Reset mid-ACCESS aborts the operation and no store is committed.
- FSM states: IDLE and ACCESS.
- Word index = alu_result[ADDR_W+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH*4 bytes.
- IDLE, stall_flag_mem_in=0, valid_in=1, MemRead=MemWrite=0:
  - At the next edge, the pass-through outputs and valid_out=1 are updated and read_data=0.
  - Latency is 1 cycle.
- IDLE, stall_flag_mem_in=0, valid_in=1, MemRead|MemWrite=1:
  - At edge E0, all inputs are latched, state goes to ACCESS, counter=ACCESS_LAT-1, mem_busy=1 and valid_out=0.
- ACCESS, stall_flag_mem_in=0:
  - Counter decrements each edge.
  - At the edge where the counter is 0 (edge E0+ACCESS_LAT), the store is committed (if MemWrite) and read_data is loaded (if MemRead).
  - At that same edge, the latched pass-through fields go to the outputs, valid_out=1, mem_busy=0 and state returns to IDLE.
- A new instruction is accepted no earlier than the edge after mem_busy falls. Back-to-back memory ops are therefore spaced ACCESS_LAT+1 cycles.
- MemRead and MemWrite both 1: the store is performed and read_data = write_data (write-first).
- Misaligned load/store (alu_result[1:0] != 0):
  - The access still takes ACCESS_LAT cycles but the memory is not written; read_data=0.
  - misaligned is set to 1 and stays 1 until reset.
- valid_out is a one-cycle pulse per completed instruction. When it is deasserted, the other outputs hold their last values.
- valid_in=0 in IDLE: nothing is accepted; valid_out=0 at the next edge.
- stall_flag_mem_in=1:
  - In any state, the FSM, counter, memory and outputs hold; valid_out is forced to 0 at the next edge.
  - mem_busy holds its value.
  - Operation resumes exactly where it froze.
- stall_flag_mem_out is updated every edge, including while stalled (0 on reset).
- The stage never reorders instructions and never drops an instruction accepted in IDLE.

Test Plan:
- Reset, then store alu_result=0x10, write_data=0xDEADBEEF; load 0x10 -> mem_busy high for 2 cycles on each op; load's valid_out pulse carries read_data=0xDEADBEEF with MemtoReg_out and rd_out echoed.
- R-type pass-through alu_result=0x00000007, rd_in=5, RegWrite=1 -> one cycle later valid_out=1, alu_result_out=7, rd_out=5, read_data=0, mem_busy never asserted.
- Wrap-around: store 0x55 to address 0x400 (DEPTH=256), then load address 0x0 -> read_data=0x55.
- Misaligned store to 0x13 with data 0x1234, then load 0x10 -> misaligned=1 and stays high; load returns 0.
- Stall mid-access: assert stall_flag_mem_in for 3 cycles after E0 of a load -> completion delayed exactly 3 cycles, valid_out=0 during the stall, stall_flag_mem_out mirrors the input one cycle late.
- Reset mid-access: store 0xAAAA to 0x20, assert reset at E0+1, then load 0x20 -> read_data=0, all outputs 0 immediately after reset.
